// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: sends a 32-bit frame or a repeat code as a carrier-gated envelope.
// All outputs are registered; the carrier counter restarts at every mark so marks begin high.
module ir_nec_tx #(
   parameter int unsigned UNIT_CYCLES  = 28125,
   parameter int unsigned CARRIER_DIV  = 1316,
   parameter int unsigned CARRIER_HIGH = 439,
   parameter int unsigned GAP_UNITS    = 72
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       repeat_req,
   input  logic [7:0] addr,
   input  logic [7:0] cmd,
   output logic       busy,
   output logic       done,
   output logic       ir_envelope,
   output logic       ir_out
);

   localparam int unsigned CYC_W  = $clog2(UNIT_CYCLES + 1);
   localparam int unsigned UNIT_W = $clog2(((GAP_UNITS > 16) ? GAP_UNITS : 16) + 1);
   localparam int unsigned CAR_W  = $clog2(CARRIER_DIV + 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      GAP
   } state_t;

   state_t              state;
   logic [CYC_W-1:0]    cyc_cnt;
   logic [UNIT_W-1:0]   unit_cnt;
   logic [4:0]          bit_idx;
   logic [31:0]         shreg;
   logic                is_repeat;
   logic [CAR_W-1:0]    car_cnt;

   logic [UNIT_W-1:0]   len_units;
   logic                unit_wrap;
   logic                seg_end;
   logic [CAR_W-1:0]    car_next;
   logic                car_on_next;

   // Length of the current state in units; shreg[0] is the bit being sent.
   always_comb begin
      len_units = UNIT_W'(1);
      case (state)
         LEAD_MARK:  len_units = UNIT_W'(16);
         LEAD_SPACE: len_units = is_repeat ? UNIT_W'(4) : UNIT_W'(8);
         BIT_MARK:   len_units = UNIT_W'(1);
         BIT_SPACE:  len_units = shreg[0] ? UNIT_W'(3) : UNIT_W'(1);
         STOP_MARK:  len_units = UNIT_W'(1);
         GAP:        len_units = UNIT_W'(GAP_UNITS);
         default:    len_units = UNIT_W'(1);
      endcase
      unit_wrap   = (cyc_cnt == CYC_W'(UNIT_CYCLES - 1));
      seg_end     = unit_wrap && (unit_cnt == len_units - UNIT_W'(1));
      car_next    = (car_cnt == CAR_W'(CARRIER_DIV - 1)) ? '0 : car_cnt + CAR_W'(1);
      car_on_next = (car_next < CAR_W'(CARRIER_HIGH));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         unit_cnt    <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         is_repeat   <= 1'b0;
         car_cnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ir_envelope <= 1'b0;
         ir_out      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && !seg_end) begin
            if (unit_wrap) begin
               cyc_cnt  <= '0;
               unit_cnt <= unit_cnt + UNIT_W'(1);
            end else begin
               cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
            car_cnt <= car_next;
            ir_out  <= ir_envelope & car_on_next;
         end else begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            car_cnt  <= '0;
            case (state)
               IDLE: begin
                  if (start || repeat_req) begin
                     shreg       <= {~cmd, cmd, ~addr, addr};
                     is_repeat   <= !start;
                     bit_idx     <= '0;
                     busy        <= 1'b1;
                     state       <= LEAD_MARK;
                     ir_envelope <= 1'b1;
                     ir_out      <= 1'b1;
                  end else begin
                     ir_envelope <= 1'b0;
                     ir_out      <= 1'b0;
                  end
               end
               LEAD_MARK: begin
                  state       <= LEAD_SPACE;
                  ir_envelope <= 1'b0;
                  ir_out      <= 1'b0;
               end
               LEAD_SPACE: begin
                  state       <= is_repeat ? STOP_MARK : BIT_MARK;
                  ir_envelope <= 1'b1;
                  ir_out      <= 1'b1;
               end
               BIT_MARK: begin
                  state       <= BIT_SPACE;
                  ir_envelope <= 1'b0;
                  ir_out      <= 1'b0;
               end
               BIT_SPACE: begin
                  if (bit_idx == 5'd31) begin
                     state <= STOP_MARK;
                  end else begin
                     bit_idx <= bit_idx + 5'd1;
                     shreg   <= {1'b0, shreg[31:1]};
                     state   <= BIT_MARK;
                  end
                  ir_envelope <= 1'b1;
                  ir_out      <= 1'b1;
               end
               STOP_MARK: begin
                  state       <= GAP;
                  ir_envelope <= 1'b0;
                  ir_out      <= 1'b0;
               end
               GAP: begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  ir_envelope <= 1'b0;
                  ir_out      <= 1'b0;
               end
               default: begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  ir_envelope <= 1'b0;
                  ir_out      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: per-cycle comparison against a segment-list model of the NEC waveform,
// plus an independent run-length NEC decoder on the observed envelope.
module tb_ir_nec_tx;

   localparam int U  = 8;
   localparam int CD = 4;
   localparam int CH = 2;
   localparam int G  = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       repeat_req;
   logic [7:0] addr;
   logic [7:0] cmd;
   logic       busy;
   logic       done;
   logic       ir_envelope;
   logic       ir_out;

   int checks   = 0;
   int failures = 0;

   bit exp_env[$];
   bit exp_out[$];
   bit obs[$];
   int runs[$];

   ir_nec_tx #(
      .UNIT_CYCLES (U),
      .CARRIER_DIV (CD),
      .CARRIER_HIGH(CH),
      .GAP_UNITS   (G)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .repeat_req (repeat_req),
      .addr       (addr),
      .cmd        (cmd),
      .busy       (busy),
      .done       (done),
      .ir_envelope(ir_envelope),
      .ir_out     (ir_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A segment of 'cycles' clocks at one envelope level; marks carry the carrier from phase 0.
   task automatic push_seg(input bit level, input int cycles);
      for (int p = 0; p < cycles; p++) begin
         exp_env.push_back(level);
         exp_out.push_back(level && ((p % CD) < CH));
      end
   endtask

   task automatic build_model(input bit is_frame, input logic [31:0] word);
      exp_env.delete();
      exp_out.delete();
      push_seg(1'b1, 16 * U);
      if (is_frame) begin
         push_seg(1'b0, 8 * U);
         for (int b = 0; b < 32; b++) begin
            push_seg(1'b1, U);
            push_seg(1'b0, word[b] ? 3 * U : U);
         end
      end else begin
         push_seg(1'b0, 4 * U);
      end
      push_seg(1'b1, U);
      push_seg(1'b0, G * U);
   endtask

   task automatic decode(input bit is_frame, input logic [31:0] word);
      logic [31:0] dec;
      runs.delete();
      for (int i = 0; i < obs.size(); i++) begin
         if (i == 0 || obs[i] != obs[i-1]) runs.push_back(1);
         else runs[runs.size()-1] = runs[runs.size()-1] + 1;
      end
      check("run_count", runs.size(), is_frame ? 68 : 4);
      if (runs.size() == 68 && is_frame) begin
         check("lead_mark", runs[0], 16 * U);
         check("lead_space", runs[1], 8 * U);
         dec = '0;
         for (int b = 0; b < 32; b++) begin
            check("bit_mark", runs[2 + 2*b], U);
            check("space_legal", (runs[3 + 2*b] == U) || (runs[3 + 2*b] == 3 * U), 1);
            dec[b] = (runs[3 + 2*b] > 2 * U);
         end
         check("decoded_word", dec, word);
         check("stop_mark", runs[66], U);
         check("gap", runs[67], G * U);
      end
      if (runs.size() == 4 && !is_frame) begin
         check("rep_lead_mark", runs[0], 16 * U);
         check("rep_lead_space", runs[1], 4 * U);
         check("rep_stop_mark", runs[2], U);
         check("rep_gap", runs[3], G * U);
      end
   endtask

   // Called at a negedge with busy=0; returns at the negedge where done should be high,
   // or after a reset pulse when abort_at is reached.
   task automatic send(input bit st, input bit rp, input logic [7:0] a, input logic [7:0] c,
                       input int pulse_at, input int abort_at);
      logic [31:0] word;
      int busy_cnt;
      bit is_frame;
      word     = {~c, c, ~a, a};
      is_frame = st;
      build_model(is_frame, word);
      start      = st;
      repeat_req = rp;
      addr       = a;
      cmd        = c;
      @(negedge clk);
      start      = 1'b0;
      repeat_req = 1'b0;
      addr       = 8'($urandom);
      cmd        = 8'($urandom);
      obs.delete();
      busy_cnt = 0;
      for (int i = 0; i < exp_env.size(); i++) begin
         check("envelope", ir_envelope, exp_env[i]);
         check("ir_out", ir_out, exp_out[i]);
         check("busy", busy, 1);
         check("done_low", done, 0);
         obs.push_back(ir_envelope);
         if (busy === 1'b1) busy_cnt++;
         if (i == abort_at) begin
            reset_n = 1'b0;
            #1;
            check("rst_ir_out", ir_out, 0);
            check("rst_envelope", ir_envelope, 0);
            check("rst_busy", busy, 0);
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         if (i == pulse_at) begin
            start = 1'b1;
            addr  = 8'($urandom);
            cmd   = 8'($urandom);
         end else if (i == pulse_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("env_end", ir_envelope, 0);
      check("busy_cycles", busy_cnt, is_frame ? (121 + G) * U : (21 + G) * U);
      decode(is_frame, word);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_env", ir_envelope, 0);
         check("idle_out", ir_out, 0);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      repeat_req = 1'b0;
      addr       = '0;
      cmd        = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_env", ir_envelope, 0);
      check("reset_out", ir_out, 0);
      reset_n = 1'b1;
      idle_cycles(2);

      send(1'b1, 1'b0, 8'h00, 8'hFF, -1, -1);
      // back-to-back: accepted in the cycle right after done
      send(1'b1, 1'b0, 8'h59, 8'h16, -1, -1);
      send(1'b0, 1'b1, 8'($urandom), 8'($urandom), -1, -1);
      send(1'b1, 1'b1, 8'($urandom), 8'($urandom), 300, -1);
      idle_cycles(1);
      send(1'b1, 1'b0, 8'($urandom), 8'($urandom), -1, 500);
      idle_cycles(3);
      send(1'b1, 1'b0, 8'($urandom), 8'($urandom), -1, -1);

      for (int n = 0; n < 6; n++) begin
         bit st;
         bit rp;
         st = 1'($urandom);
         rp = st ? 1'($urandom) : 1'b1;
         idle_cycles($urandom_range(0, 2));
         send(st, rp, 8'($urandom), 8'($urandom), -1, -1);
      end
      idle_cycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
